mem_rd_arbiter: RTL

Shares the single doubleword read port of the `mem` model between two requesters in the PPC core: instruction fetch (F) and `ld`/`ldu` data loads (L). The block issues at most one read per cycle and tracks outstanding reads in an in-order tag FIFO. It routes each returned doubleword to the requester that issued it. It sits between the core's fetch and load stages and the memory read port, replacing the fixed port-0/port-1 split.

---
 rtl/mem_rd_arbiter_if.sv | 39 +++
 rtl/mem_rd_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mem_rd_arbiter_if.sv
// mem_rd_arbiter_if: fetch/load request and return signals plus the shared
// memory read port, as seen by the arbiter (master) and its environment (slave).
// Bit numbering follows the core: address [0:60], data [0:63], bit 0 is MSB.
interface mem_rd_arbiter_if;
    logic        f_req;
    logic [0:60] f_addr;
    logic        f_gnt;
    logic        f_rvalid;
    logic [0:63] f_rdata;

    logic        l_req;
    logic [0:60] l_addr;
    logic        l_gnt;
    logic        l_rvalid;
    logic [0:63] l_rdata;

    logic        mem_req;
    logic [0:60] mem_addr;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [0:63] mem_rdata;

    logic [2:0]  outstanding;
    logic        err;

    // arbiter side
    modport master (
        input  f_req, f_addr, l_req, l_addr, mem_ready, mem_rvalid, mem_rdata,
        output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
        output mem_req, mem_addr, outstanding, err
    );

    // requesters and memory side
    modport slave (
        output f_req, f_addr, l_req, l_addr, mem_ready, mem_rvalid, mem_rdata,
        input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
        input  mem_req, mem_addr, outstanding, err
    );
endinterface

// File: rtl/mem_rd_arbiter.sv
// mem_rd_arbiter: shares the single doubleword memory read port between
// instruction fetch (F) and data loads (L). One issue per cycle; an in-order
// tag FIFO remembers who issued each outstanding read so returns are routed
// back to the right requester one cycle after mem_rvalid.
//
// Build option ARB_RR_EN: when defined, contested cycles alternate
// (priority to the loser of the last contested grant, F first after reset).
// When undefined, L wins contested cycles until it has taken STARVE_MAX
// consecutive contested grants, then F wins once.
//
// MAX_OUT must be in 1..7 because outstanding is a 3-bit count.
module mem_rd_arbiter #(
    parameter int MAX_OUT    = 4,
    parameter int STARVE_MAX = 3
) (
    input logic              clk,
    input logic              rst,
    mem_rd_arbiter_if.master bus
);
    localparam int             PTR_W    = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUT - 1);
    localparam logic [2:0]     OUT_MAX  = 3'(MAX_OUT);

    typedef enum logic {TAG_F = 1'b0, TAG_L = 1'b1} tagT;

    tagT              tagMem [MAX_OUT];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [2:0]       count;
    tagT              headTag;

    logic fifoFull;
    logic fifoEmpty;
    logic canIssue;
    logic fWins;
    logic memReq;
    logic fGnt;
    logic lGnt;
    logic doPush;
    logic doPop;

    logic        fRvalidQ;
    logic        lRvalidQ;
    logic [0:63] fRdataQ;
    logic [0:63] lRdataQ;
    logic        errQ;

`ifdef ARB_RR_EN
    logic rrPrioF;
`else
    localparam int STARVE_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_MAX);
    logic [STARVE_W-1:0] starveCnt;
`endif

    assign headTag = tagMem[rdPtr];

    // Issue eligibility, winner selection and same-cycle grant
    always_comb begin
        fifoFull  = (count == OUT_MAX);
        fifoEmpty = (count == 3'd0);
        // a return this cycle frees a slot, so a full FIFO can still issue
        canIssue  = !rst && (!fifoFull || bus.mem_rvalid);
        if (bus.f_req && bus.l_req) begin
`ifdef ARB_RR_EN
            fWins = rrPrioF;
`else
            fWins = (starveCnt == STARVE_TOP);
`endif
        end else begin
            fWins = bus.f_req;
        end
        memReq = canIssue && (bus.f_req || bus.l_req);
        fGnt   = memReq && bus.mem_ready && fWins;
        lGnt   = memReq && bus.mem_ready && !fWins;
        doPush = fGnt || lGnt;
        // occupancy is judged before this cycle's push
        doPop  = !rst && bus.mem_rvalid && !fifoEmpty;
    end

    // Tag FIFO pointers and occupancy count
    always_ff @(posedge clk) begin
        if (rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= 3'd0;
        end else begin
            if (doPush) wrPtr <= (wrPtr == PTR_LAST) ? '0 : wrPtr + 1'b1;
            if (doPop)  rdPtr <= (rdPtr == PTR_LAST) ? '0 : rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Tag storage; stale entries are harmless because pointers gate use
    always_ff @(posedge clk) begin
        if (doPush) tagMem[wrPtr] <= lGnt ? TAG_L : TAG_F;
    end

    // Route returned data to the issuing requester; flag orphan returns
    always_ff @(posedge clk) begin
        if (rst) begin
            fRvalidQ <= 1'b0;
            lRvalidQ <= 1'b0;
            fRdataQ  <= '0;
            lRdataQ  <= '0;
            errQ     <= 1'b0;
        end else begin
            fRvalidQ <= doPop && (headTag == TAG_F);
            lRvalidQ <= doPop && (headTag == TAG_L);
            if (doPop && (headTag == TAG_F)) fRdataQ <= bus.mem_rdata;
            if (doPop && (headTag == TAG_L)) lRdataQ <= bus.mem_rdata;
            if (bus.mem_rvalid && fifoEmpty) errQ <= 1'b1;
        end
    end

`ifdef ARB_RR_EN
    // Round-robin: the loser of a contested grant gets the next contested one
    always_ff @(posedge clk) begin
        if (rst) begin
            rrPrioF <= 1'b1;
        end else if (bus.f_req && bus.l_req && doPush) begin
            rrPrioF <= lGnt;
        end
    end
`else
    // Count consecutive contested L grants; any F grant or idle F clears it
    always_ff @(posedge clk) begin
        if (rst || !bus.f_req || fGnt) begin
            starveCnt <= '0;
        end else if (lGnt && (starveCnt != STARVE_TOP)) begin
            starveCnt <= starveCnt + 1'b1;
        end
    end
`endif

    assign bus.mem_req     = memReq;
    assign bus.mem_addr    = fWins ? bus.f_addr : bus.l_addr;
    assign bus.f_gnt       = fGnt;
    assign bus.l_gnt       = lGnt;
    assign bus.f_rvalid    = fRvalidQ;
    assign bus.l_rvalid    = lRvalidQ;
    assign bus.f_rdata     = fRdataQ;
    assign bus.l_rdata     = lRdataQ;
    assign bus.outstanding = count;
    assign bus.err         = errQ;
endmodule
